// File: rtl/ysyx_22050243_lsu_ctrl_if.sv
// Data-memory port bundle for the LSU controller.
//   master : controller side. Drives the request and its payload, and receives
//            request-ready, the response strobe and read data.
//   slave  : memory side. This is the opposite view of the same signals.
// Signals:
//   dmem_req_valid / dmem_req_ready : request handshake.
//   dmem_we                         : 1 = write, 0 = read.
//   dmem_addr                       : 8-byte aligned address.
//   dmem_wdata / dmem_wmask         : lane-shifted store data and byte strobes.
//   dmem_rsp_valid / dmem_rdata     : read data or write acknowledge.
interface ysyx_22050243_lsu_ctrl_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             dmem_req_valid;
  logic             dmem_req_ready;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic [7:0]       dmem_wmask;
  logic             dmem_rsp_valid;
  logic [WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wmask,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wmask,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rdata
  );
endinterface

// File: rtl/ysyx_22050243_lsu_ctrl.sv
// MEM-stage load/store sequencer. It accepts one memory operation at a time
// and keeps only one request outstanding to data memory. For stores it builds
// lane-aligned write data and byte strobes. For loads it extracts the addressed
// bytes and sign- or zero-extends them. Misaligned and illegal operations
// complete with an error pulse and generate no memory traffic.
// Ports:
//   clk, rst        : clock and synchronous active-high reset.
//   req_valid/ready : operation handshake from the MEM stage.
//   mem_w, mem_r    : store / load select.
//   funct3          : RV64 size and sign code.
//   addr, wdata     : byte address and store source.
//   resp_valid      : one-cycle completion pulse.
//   resp_data       : extended load result (0 for stores and errors).
//   stall           : holds the upstream pipeline while an operation is busy.
//   err             : one-cycle pulse with resp_valid on a bad operation.
//   dmem            : data-memory port (master view).
// WIDTH must be 64: the lane logic assumes 8 byte lanes and a 3-bit offset.
module ysyx_22050243_lsu_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             mem_w,
  input  logic                             mem_r,
  input  logic [2:0]                       funct3,
  input  logic [WIDTH-1:0]                 addr,
  input  logic [WIDTH-1:0]                 wdata,
  output logic                             resp_valid,
  output logic [WIDTH-1:0]                 resp_data,
  output logic                             stall,
  output logic                             err,
  ysyx_22050243_lsu_ctrl_if.master         dmem
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [2:0]       off_q, off_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]       wmask_q, wmask_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  // Decode of the operation presented at the input.
  logic             illegal;
  logic             misaligned;
  logic             is_access;
  logic [7:0]       base_mask;
  logic [7:0]       new_wmask;
  logic [WIDTH-1:0] new_wdata;

  // Load extraction from the response data.
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_ext;

  always_comb begin
    is_access = mem_w | mem_r;
    illegal   = (mem_w & mem_r) | (funct3 == 3'b111) | (mem_w & funct3[2]);

    misaligned = 1'b0;
    base_mask  = 8'h00;
    case (funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        base_mask  = 8'h01;
      end
      2'b01: begin
        misaligned = addr[0];
        base_mask  = 8'h03;
      end
      2'b10: begin
        misaligned = |addr[1:0];
        base_mask  = 8'h0f;
      end
      default: begin
        misaligned = |addr[2:0];
        base_mask  = 8'hff;
      end
    endcase
    // A no-op has no memory access, so its address cannot be misaligned.
    misaligned = misaligned & is_access;

    new_wmask = mem_w ? (base_mask << addr[2:0]) : 8'h00;
    new_wdata = wdata << {addr[2:0], 3'b000};
  end

  always_comb begin
    shifted  = dmem.dmem_rdata >> {off_q, 3'b000};
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{(WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_ext = shifted;
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      3'b110:  load_ext = {{(WIDTH-32){1'b0}}, shifted[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Next-state and latch updates.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    data_d   = data_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = mem_w;
          funct3_d = funct3;
          off_d    = addr[2:0];
          addr_d   = {addr[WIDTH-1:3], 3'b000};
          wdata_d  = new_wdata;
          wmask_d  = new_wmask;
          data_d   = '0;
          err_d    = illegal | misaligned;
          // Bad ops and no-ops complete without touching memory.
          if (illegal || misaligned || !is_access) begin
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dmem.dmem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (dmem.dmem_rsp_valid) begin
          data_d  = we_q ? '0 : load_ext;
          state_d = StResp;
        end
      end
      StResp: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= 8'h00;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_data  = (state_q == StResp) ? data_q : '0;
    err        = (state_q == StResp) & err_q;
    stall      = ((state_q == StIdle) & req_valid) | (state_q == StReq) | (state_q == StWait);

    dmem.dmem_req_valid = (state_q == StReq);
    dmem.dmem_we        = we_q;
    dmem.dmem_addr      = addr_q;
    dmem.dmem_wdata     = wdata_q;
    dmem.dmem_wmask     = wmask_q;
  end

endmodule

// File: tb/tb_ysyx_22050243_lsu_ctrl.sv
module tb_ysyx_22050243_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_w;
  logic        mem_r;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        stall;
  logic        err;

  ysyx_22050243_lsu_ctrl_if #(.WIDTH(64)) dmem_bus ();

  ysyx_22050243_lsu_ctrl #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_w      (mem_w),
    .mem_r      (mem_r),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .stall      (stall),
    .err        (err),
    .dmem       (dmem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expectations for the operation in flight.
  bit          e_mem, e_err, e_we;
  bit [63:0]   e_addr, e_wdata, e_data;
  bit [7:0]    e_wmask;
  int          e_lat, e_rdly;
  bit          in_flight = 0;
  int          cur_cyc = 0;
  bit          chk_en = 0;

  // Observations recorded for the directed pins.
  logic [63:0] last_addr, last_wdata, last_resp;
  logic [7:0]  last_wmask;
  logic        last_we;
  int          req_cnt = 0, resp_cnt = 0, err_cnt = 0;

  // Reference behaviour, written from the architectural rules.
  function automatic void model(input bit mw, input bit mr, input bit [2:0] f3,
                                input bit [63:0] a, input bit [63:0] wd, input bit [63:0] rd);
    int unsigned size, off;
    bit [63:0]   v, lim;
    size    = 1 << f3[1:0];
    off     = a % 8;
    e_err   = (mw && mr) || (f3 == 3'd7) || (mw && f3 >= 3'd4) ||
              ((mw || mr) && (off % size != 0));
    e_mem   = (mw || mr) && !e_err;
    e_we    = mw;
    e_addr  = a - 64'(off);
    e_wdata = wd << (8 * off);
    e_wmask = mw ? 8'(((1 << size) - 1) << off) : 8'h00;
    v = 64'd0;
    if (e_mem && mr) begin
      v = rd >> (8 * off);
      if (size < 8) begin
        lim = 64'd1 << (8 * size);
        v   = v % lim;
        if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
      end
    end
    e_data = v;
  endfunction

  // Per-cycle compare against the transaction-level expectation.
  always @(negedge clk) begin
    if (dmem_bus.dmem_req_valid) begin
      req_cnt++;
      last_addr  = dmem_bus.dmem_addr;
      last_wdata = dmem_bus.dmem_wdata;
      last_wmask = dmem_bus.dmem_wmask;
      last_we    = dmem_bus.dmem_we;
    end
    if (resp_valid) begin
      resp_cnt++;
      last_resp = resp_data;
      if (err) err_cnt++;
    end
    if (chk_en && !rst) begin
      bit exp_resp, exp_reqv;
      exp_resp = in_flight && (cur_cyc == e_lat);
      exp_reqv = in_flight && e_mem && (cur_cyc >= 1) && (cur_cyc <= 1 + e_rdly);
      chk("resp_valid", resp_valid, exp_resp);
      chk("req_ready", req_ready, !in_flight);
      chk("stall", stall, in_flight ? !exp_resp : req_valid);
      chk("dmem_req_valid", dmem_bus.dmem_req_valid, exp_reqv);
      chk("err", err, exp_resp && e_err);
      if (exp_resp) chk("resp_data", resp_data, e_data);
      if (exp_reqv) begin
        chk("dmem_addr", dmem_bus.dmem_addr, e_addr);
        chk("dmem_we", dmem_bus.dmem_we, e_we);
        chk("dmem_wdata", dmem_bus.dmem_wdata, e_wdata);
        chk("dmem_wmask", dmem_bus.dmem_wmask, e_wmask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation, acting as the memory with the given delays.
  // The task is entered and left 1 time unit after a rising edge.
  task automatic run_op(input bit mw, input bit mr, input bit [2:0] f3, input bit [63:0] a,
                        input bit [63:0] wd, input bit [63:0] rd, input int rdly, input int sdly);
    bit hs, delivered;
    int rw, sw;
    model(mw, mr, f3, a, wd, rd);
    e_rdly = rdly;
    e_lat  = e_mem ? 3 + rdly + sdly : 1;
    req_valid = 1'b1;
    mem_w     = mw;
    mem_r     = mr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    tick();
    // The inputs are scrambled after acceptance so that latching is exercised.
    req_valid = 1'b0;
    mem_w     = 1'($urandom);
    mem_r     = 1'($urandom);
    funct3    = 3'($urandom);
    addr      = {$urandom, $urandom};
    wdata     = {$urandom, $urandom};
    in_flight = 1'b1;
    hs = 0; delivered = 0; rw = 0; sw = 0;
    for (int cyc = 1; cyc <= e_lat; cyc++) begin
      cur_cyc = cyc;
      dmem_bus.dmem_rdata = {$urandom, $urandom};
      if (!hs) begin
        dmem_bus.dmem_rsp_valid = 1'($urandom);
        if (e_mem) begin
          dmem_bus.dmem_req_ready = dmem_bus.dmem_req_valid && (rw == rdly);
          if (dmem_bus.dmem_req_valid) rw++;
          if (dmem_bus.dmem_req_ready) hs = 1;
        end else begin
          dmem_bus.dmem_req_ready = 1'($urandom);
        end
      end else begin
        dmem_bus.dmem_req_ready = 1'($urandom);
        if (!delivered) begin
          dmem_bus.dmem_rsp_valid = (sw == sdly);
          if (sw == sdly) begin
            dmem_bus.dmem_rdata = rd;
            delivered = 1;
          end
          sw++;
        end else begin
          dmem_bus.dmem_rsp_valid = 1'($urandom);
        end
      end
      tick();
    end
    in_flight               = 1'b0;
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, x0;
    rst = 1'b1;
    req_valid = 0; mem_w = 0; mem_r = 0; funct3 = 0; addr = 0; wdata = 0;
    dmem_bus.dmem_req_ready = 0;
    dmem_bus.dmem_rsp_valid = 0;
    dmem_bus.dmem_rdata     = 0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_dmem_req_valid", dmem_bus.dmem_req_valid, 0);
    chk("rst_dmem_wmask", dmem_bus.dmem_wmask, 0);
    tick();
    chk_en = 1;

    // Store byte, immediate ready and acknowledge.
    run_op(1, 0, 3'b000, 64'h8000_0005, 64'h0123_4567_89ab_cdab, 64'h0, 0, 0);
    chk("pin_sb_addr", last_addr, 64'h8000_0000);
    chk("pin_sb_wmask", last_wmask, 8'h20);
    chk("pin_sb_byte5", last_wdata[47:40], 8'hab);
    chk("pin_sb_we", last_we, 1);
    chk("pin_sb_data", last_resp, 64'h0);

    // Word loads, signed and unsigned.
    run_op(0, 1, 3'b010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0);
    chk("pin_lw", last_resp, 64'hffff_ffff_8765_4321);
    run_op(0, 1, 3'b110, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0);
    chk("pin_lwu", last_resp, 64'h0000_0000_8765_4321);

    // Backpressure on both request and response.
    r0 = resp_cnt;
    run_op(0, 1, 3'b001, 64'h8000_0106, 64'h0, 64'hbeef_0000_0000_0000, 4, 3);
    chk("pin_bp_lh", last_resp, 64'hffff_ffff_ffff_beef);
    chk("pin_bp_one_resp", resp_cnt - r0, 1);

    // Misaligned doubleword load.
    c0 = req_cnt; x0 = err_cnt;
    run_op(0, 1, 3'b011, 64'h8000_0004, 64'h0, 64'h1, 0, 0);
    chk("pin_mis_noreq", req_cnt - c0, 0);
    chk("pin_mis_err", err_cnt - x0, 1);
    chk("pin_mis_data", last_resp, 64'h0);

    // Illegal combinations and the no-op.
    c0 = req_cnt; x0 = err_cnt;
    run_op(1, 1, 3'b000, 64'h8000_0000, 64'h5, 64'h0, 0, 0);
    run_op(1, 0, 3'b100, 64'h8000_0000, 64'h5, 64'h0, 0, 0);
    chk("pin_illegal_err", err_cnt - x0, 2);
    x0 = err_cnt; r0 = resp_cnt;
    run_op(0, 0, 3'b000, 64'h8000_0000, 64'h5, 64'h0, 0, 0);
    chk("pin_noop_err", err_cnt - x0, 0);
    chk("pin_noop_resp", resp_cnt - r0, 1);
    chk("pin_illegal_noreq", req_cnt - c0, 0);

    // Reset while waiting for the response.
    chk_en = 0;
    r0 = resp_cnt;
    req_valid = 1; mem_w = 0; mem_r = 1; funct3 = 3'b011; addr = 64'h1000_0008;
    tick();
    req_valid = 0;
    dmem_bus.dmem_req_ready = 1;
    tick();
    dmem_bus.dmem_req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    dmem_bus.dmem_rsp_valid = 1;
    dmem_bus.dmem_rdata     = 64'hdead_beef_dead_beef;
    @(negedge clk);
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_stall", stall, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_dmem_req_valid", dmem_bus.dmem_req_valid, 0);
    chk("rstw_dmem_addr", dmem_bus.dmem_addr, 0);
    chk("rstw_dmem_wdata", dmem_bus.dmem_wdata, 0);
    chk("rstw_dmem_wmask", dmem_bus.dmem_wmask, 0);
    chk("rstw_dmem_we", dmem_bus.dmem_we, 0);
    chk("rstw_resp_data", resp_data, 0);
    tick();
    dmem_bus.dmem_rsp_valid = 0;
    @(negedge clk);
    chk("rstw_no_resp", resp_cnt - r0, 0);
    tick();
    chk_en = 1;
    run_op(0, 1, 3'b011, 64'h1000_0008, 64'h0, 64'h0102_0304_0506_0708, 1, 1);
    chk("pin_after_rst", last_resp, 64'h0102_0304_0506_0708);

    // Randomized operations.
    for (int n = 0; n < 250; n++) begin
      int          r;
      bit          mw, mr;
      bit [2:0]    f3;
      bit [63:0]   a;
      r = $urandom_range(0, 99);
      mw = (r >= 45 && r < 80) || r >= 90;
      mr = r < 45 || r >= 90;
      f3 = (mw || mr) ? 3'($urandom_range(0, 7)) : 3'b000;
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      run_op(mw, mr, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 4), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_lsu_ctrl.md
Name: ysyx_22050243_lsu_ctrl

Overview:
Load/store sequencing controller in the MEM stage. It accepts one memory operation per request. For stores it builds byte-lane-aligned write data and write mask. It drives a single-outstanding request/response handshake to the data memory port and extracts and extends load data. It stalls the pipeline from acceptance until the response cycle and flags misaligned or illegal accesses without touching memory.

Parameters:
WIDTH, 64, data/address width in bits; must be 64 (8 byte lanes, 3-bit lane offset).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  MEM stage presents a memory op.
req_ready  output  1  controller accepts op this cycle.
mem_w  input  1  store op.
mem_r  input  1  load op.
funct3  input  3  RV64 size/sign code (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu).
addr  input  WIDTH  byte address.
wdata  input  WIDTH  store source (rs2).
dmem_req_valid  output  1  request to data memory.
dmem_req_ready  input  1  memory accepts request.
dmem_we  output  1  1 = write, 0 = read.
dmem_addr  output  WIDTH  addr with bits [2:0] cleared.
dmem_wdata  output  WIDTH  lane-shifted store data.
dmem_wmask  output  8  byte-lane write strobes.
dmem_rsp_valid  input  1  read data / write ack valid.
dmem_rdata  input  WIDTH  8-byte-aligned read data.
resp_valid  output  1  one-cycle completion pulse.
resp_data  output  WIDTH  extended load result; 0 for stores.
stall  output  1  hold upstream pipeline.
err  output  1  one-cycle pulse: misaligned or illegal op.

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset forces IDLE. Reset clears every registered output and latch to 0. Reset mid-operation abandons the transaction; any later dmem_rsp_valid is ignored in IDLE.
- req_ready = (state==IDLE).
- Acceptance is req_valid && req_ready. At acceptance, latch mem_w, funct3, addr[2:0], dmem_addr, dmem_wdata and dmem_wmask.
- Legality check at acceptance:
  - mem_w && mem_r is illegal.
  - funct3 = 111 is illegal.
  - mem_w with funct3[2]=1 is illegal.
  - Neither mem_w nor mem_r: accept and go directly to RESP with resp_data=0 and no memory traffic.
- Misalignment: h requires addr[0]=0; w requires addr[1:0]=0; d requires addr[2:0]=0.
- Illegal or misaligned op: go to RESP, err pulses in the RESP cycle, resp_data=0, no dmem request.
- Legal op: IDLE -> REQ. Hold dmem_req_valid=1 with stable payload until the cycle dmem_req_ready=1, then go to WAIT.
- WAIT: on dmem_rsp_valid, capture the data and go to RESP. Stores also wait for the ack.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request may be accepted in the cycle after RESP.
- Minimum latency (ready and rsp immediate): accept at T, REQ at T+1, WAIT at T+2, RESP at T+3.
- dmem_wmask base pattern is 0x01 / 0x03 / 0x0F / 0xFF for b / h / w / d, shifted left by addr[2:0]. It is 0 for reads.
- dmem_wdata = wdata shifted left by 8*addr[2:0]; bytes outside the mask are don't-care but driven deterministically.
- Load extraction: shift dmem_rdata right by 8*addr[2:0], take the low 8/16/32/64 bits.
  - Sign-extend for 000/001/010.
  - Zero-extend for 100/101/110.
- stall = (state==IDLE && req_valid) || state==REQ || state==WAIT. It is 0 in RESP, so the pipeline advances with resp_data.
- dmem_rsp_valid outside WAIT is ignored. dmem_req_ready outside REQ is ignored.

Test Plan:
- Store byte: addr=0x8000_0005, funct3=000, wdata=0x...AB -> dmem_addr=0x8000_0000, wmask=0x20, wdata byte5=0xAB, dmem_we=1; resp_valid 3 cycles after accept with ready/ack immediate.
- Load word signed: addr=0x...04, funct3=010, rdata=0x8765_4321_0000_0000 -> resp_data=0xFFFF_FFFF_8765_4321. Same with funct3=110 -> 0x0000_0000_8765_4321.
- Backpressure: hold dmem_req_ready=0 for 4 cycles, then delay rsp 3 cycles -> dmem_req_valid and payload stable throughout; stall high until RESP; exactly one resp_valid.
- Misaligned: funct3=011, addr=0x...04 -> no dmem_req_valid; err=1 and resp_valid=1 in same cycle, resp_data=0.
- Illegal: mem_w=mem_r=1 -> err pulse. mem_w with funct3=100 -> err pulse. Neither mem_w nor mem_r -> resp_valid without err or dmem traffic.
- Reset in WAIT: assert rst one cycle, then inject dmem_rsp_valid -> state IDLE, all outputs 0, no resp_valid; the next request proceeds normally.
